// File: rtl/chip8_seq_alu.sv
// chip8_seq_alu: registered, handshaked CHIP-8 ALU.
// Sits between the CPU decode stage and the register file. Every result is
// registered together with the CHIP-8 VF flag. The FX33 BCD conversion runs
// as a multi-cycle double-dabble, one operand bit per clock, MSB first.
//
// Handshake: a request is taken when in_valid & in_ready, and in_ready is
// high only in IDLE. A result leaves when out_valid & out_ready, and
// out_valid is high only in DONE. Because IDLE and DONE are distinct states,
// no request can be accepted in the same cycle that a result transfers.
// result/flag/bcd do not change while out_valid is high.
module chip8_seq_alu #(
    parameter int WIDTH      = 8,
    parameter int BCD_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              op,
    input  logic [WIDTH-1:0]        a,
    input  logic [WIDTH-1:0]        b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        result,
    output logic                    flag,
    output logic [4*BCD_DIGITS-1:0] bcd,
    output logic [1:0]              o_dbg_state
);

    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int CW    = $clog2(WIDTH);

    // FSM encoding, also exported on o_dbg_state
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BCD_RUN = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    // Opcodes
    localparam logic [3:0] OP_OR   = 4'h0;
    localparam logic [3:0] OP_AND  = 4'h1;
    localparam logic [3:0] OP_XOR  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_SUBN = 4'h5;
    localparam logic [3:0] OP_SHR  = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_EQ   = 4'h8;
    localparam logic [3:0] OP_GT   = 4'h9;
    localparam logic [3:0] OP_INC  = 4'hA;
    localparam logic [3:0] OP_BCD  = 4'hB;

    // Iteration index of the final double-dabble step
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    logic [1:0]             r_state;
    logic [WIDTH-1:0]       r_result;
    logic                   r_flag;
    logic [BCD_W-1:0]       r_bcd;
    logic [WIDTH-1:0]       r_shift;
    logic [CW-1:0]          r_cnt;

    logic                   w_accept;
    logic [WIDTH:0]         w_sum;
    logic [WIDTH-1:0]       w_diff_ab;
    logic [WIDTH-1:0]       w_diff_ba;
    logic [WIDTH-1:0]       w_alu_result;
    logic                   w_alu_flag;
    logic [BCD_W-1:0]       w_bcd_adj;
    logic [BCD_W+WIDTH-1:0] w_dd_next;

    assign w_accept  = in_valid & in_ready;
    assign w_sum     = {1'b0, a} + {1'b0, b};
    assign w_diff_ab = a - b;
    assign w_diff_ba = b - a;

    // Single-cycle result and VF flag, computed from the live request inputs
    always_comb begin
        w_alu_result = '0;
        w_alu_flag   = 1'b0;
        case (op)
            OP_OR:   w_alu_result = a | b;
            OP_AND:  w_alu_result = a & b;
            OP_XOR:  w_alu_result = a ^ b;
            OP_ADD: begin
                w_alu_result = w_sum[WIDTH-1:0];
                w_alu_flag   = w_sum[WIDTH];
            end
            OP_SUB: begin
                // VF set means "no borrow" on CHIP-8
                w_alu_result = w_diff_ab;
                w_alu_flag   = (a >= b);
            end
            OP_SUBN: begin
                w_alu_result = w_diff_ba;
                w_alu_flag   = (b >= a);
            end
            OP_SHR: begin
                w_alu_result = {1'b0, a[WIDTH-1:1]};
                w_alu_flag   = a[0];
            end
            OP_SHL: begin
                w_alu_result = {a[WIDTH-2:0], 1'b0};
                w_alu_flag   = a[WIDTH-1];
            end
            OP_EQ:   w_alu_result = WIDTH'(a == b);
            OP_GT:   w_alu_result = WIDTH'(a > b);
            OP_INC:  w_alu_result = a + WIDTH'(1);
            // BCD passes the operand through as its result
            OP_BCD:  w_alu_result = a;
            default: begin
                w_alu_result = '0;
                w_alu_flag   = 1'b0;
            end
        endcase
    end

    // Double-dabble add-3 correction on every BCD digit that is 5 or more
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Corrected digits and remaining operand bits shift left as one vector,
    // pulling the next operand MSB into the lowest BCD digit
    assign w_dd_next = {w_bcd_adj, r_shift} << 1;

    // Control FSM plus result, flag, BCD and iteration registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_result <= '0;
            r_flag   <= 1'b0;
            r_bcd    <= '0;
            r_shift  <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_result <= w_alu_result;
                        r_flag   <= w_alu_flag;
                        r_bcd    <= '0;
                        r_shift  <= a;
                        r_cnt    <= '0;
                        r_state  <= (op == OP_BCD) ? ST_BCD_RUN : ST_DONE;
                    end
                end
                ST_BCD_RUN: begin
                    r_bcd   <= w_dd_next[BCD_W+WIDTH-1:WIDTH];
                    r_shift <= w_dd_next[WIDTH-1:0];
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == LAST_ITER) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == ST_IDLE);
    assign out_valid   = (r_state == ST_DONE);
    assign result      = r_result;
    assign flag        = r_flag;
    assign bcd         = r_bcd;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_chip8_seq_alu.sv
// tb_chip8_seq_alu: directed and random stimulus for chip8_seq_alu with a
// queue scoreboard of expected result/flag/bcd values.
module tb_chip8_seq_alu;
  localparam int W  = 8;
  localparam int BW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          flag;
  logic [BW-1:0] bcd;
  logic [1:0]    dbg_state;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0]  exp_res_q[$];
  logic          exp_flag_q[$];
  logic [BW-1:0] exp_bcd_q[$];

  chip8_seq_alu #(.WIDTH(W), .BCD_DIGITS(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .flag        (flag),
    .bcd         (bcd),
    .o_dbg_state (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: {flag, result}
  function automatic logic [W:0] model_alu(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    case (o)
      4'h0: return {1'b0, x | y};
      4'h1: return {1'b0, x & y};
      4'h2: return {1'b0, x ^ y};
      4'h3: return {1'b0, x} + {1'b0, y};
      4'h4: return {(x >= y), W'(x - y)};
      4'h5: return {(y >= x), W'(y - x)};
      4'h6: return {x[0], W'(x >> 1)};
      4'h7: return {x[W-1], W'(x << 1)};
      4'h8: return {1'b0, W'(x == y)};
      4'h9: return {1'b0, W'(x > y)};
      4'hA: return {1'b0, W'(x + 1)};
      4'hB: return {1'b0, x};
      default: return '0;
    endcase
  endfunction

  function automatic logic [BW-1:0] model_bcd(input logic [3:0] o, input logic [W-1:0] x);
    if (o != 4'hB) return '0;
    return {4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver + scoreboard consumer for one operation
  task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] er, input logic ef, input logic [BW-1:0] eb, input int hold);
    int n;
    int exp_lat;
    logic busy_ok;
    logic [W-1:0] e_r;
    logic e_f;
    logic [BW-1:0] e_b;
    exp_lat = (o == 4'hB) ? W + 1 : 1;
    exp_res_q.push_back(er);
    exp_flag_q.push_back(ef);
    exp_bcd_q.push_back(eb);

    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = y;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept"}, 32'(in_ready), 32'd1);

    // accept edge passes; scramble inputs while keeping a request pending
    @(negedge clk);
    op = 4'($urandom_range(0, 15)); a = W'($urandom); b = W'($urandom);
    n = 1;
    busy_ok = 1'b1;
    while (!out_valid && n < 50) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    if (in_ready) busy_ok = 1'b0;
    in_valid = 1'b0;
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    chk({tag, "_busy"}, 32'(busy_ok), 32'd1);

    for (int k = 0; k < hold; k++) begin
      chk({tag, "_hold_res"}, 32'(result), 32'(er));
      chk({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
      @(negedge clk);
    end

    e_r = exp_res_q.pop_front();
    e_f = exp_flag_q.pop_front();
    e_b = exp_bcd_q.pop_front();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_result"}, 32'(result), 32'(e_r));
    chk({tag, "_flag"}, 32'(flag), 32'(e_f));
    chk({tag, "_bcd"}, 32'(bcd), 32'(e_b));

    // transfer with a competing request present: must not be accepted
    in_valid = 1'b1; op = 4'($urandom_range(0, 15)); out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_post_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [3:0]   ro;
    logic [W-1:0] rx;
    logic [W-1:0] ry;
    logic [W:0]   m;

    // reset
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = 4'h0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flag", 32'(flag), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;

    // directed cases
    run_op("add_ff_01",  4'h3, 8'hFF, 8'h01, 8'h00, 1'b1, 12'h000, 0);
    run_op("sub_05_07",  4'h4, 8'h05, 8'h07, 8'hFE, 1'b0, 12'h000, 0);
    run_op("sub_10_10",  4'h4, 8'h10, 8'h10, 8'h00, 1'b1, 12'h000, 0);
    run_op("subn_05_07", 4'h5, 8'h05, 8'h07, 8'h02, 1'b1, 12'h000, 0);
    run_op("shl_81",     4'h7, 8'h81, 8'h00, 8'h02, 1'b1, 12'h000, 0);
    run_op("shr_81",     4'h6, 8'h81, 8'h00, 8'h40, 1'b1, 12'h000, 0);
    run_op("inc_ff",     4'hA, 8'hFF, 8'h00, 8'h00, 1'b0, 12'h000, 0);
    run_op("illegal_d",  4'hD, 8'h5A, 8'hA5, 8'h00, 1'b0, 12'h000, 0);
    run_op("or",         4'h0, 8'hF0, 8'h0C, 8'hFC, 1'b0, 12'h000, 0);
    run_op("and",        4'h1, 8'hF0, 8'h3C, 8'h30, 1'b0, 12'h000, 0);
    run_op("xor",        4'h2, 8'hFF, 8'h0F, 8'hF0, 1'b0, 12'h000, 0);
    run_op("eq",         4'h8, 8'h55, 8'h55, 8'h01, 1'b0, 12'h000, 0);
    run_op("gt_80_7f",   4'h9, 8'h80, 8'h7F, 8'h01, 1'b0, 12'h000, 0);
    run_op("gt_03_07",   4'h9, 8'h03, 8'h07, 8'h00, 1'b0, 12'h000, 0);
    run_op("bcd_fe",     4'hB, 8'hFE, 8'h00, 8'hFE, 1'b0, 12'h254, 0);
    run_op("add_after_bcd", 4'h3, 8'h01, 8'h02, 8'h03, 1'b0, 12'h000, 0);
    run_op("backpressure", 4'h3, 8'h12, 8'h34, 8'h46, 1'b0, 12'h000, 5);

    // reset three cycles into a BCD run
    @(negedge clk);
    in_valid = 1'b1; op = 4'hB; a = 8'hFE; b = 8'h00;
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort_running", 32'(dbg_state), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_bcd", 32'(bcd), 32'd0);
    run_op("after_abort_bcd", 4'hB, 8'h63, 8'h00, 8'h63, 1'b0, 12'h099, 1);

    // random ops against the model
    for (int i = 0; i < 12; i++) begin
      ro = 4'($urandom_range(0, 15));
      rx = W'($urandom_range(0, 255));
      ry = W'($urandom_range(0, 255));
      m  = model_alu(ro, rx, ry);
      run_op("rand", ro, rx, ry, m[W-1:0], m[W], model_bcd(ro, rx), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
